// File: rtl/psx_pad_engine.sv
// PSX/DualShock pad master: clock-enable timebase, serial poll FSM and frame decoder.
// Drives CLK/SEL/CMD, shifts DATA in LSB first and latches buttons/sticks on valid frames.
module psx_pad_engine #(
    parameter int HALF_DIV    = 100,
    parameter int BYTE_GAP    = 4,
    parameter int POLL_PERIOD = 4000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps_rxd,
    output logic       ps_clk,
    output logic       ps_sel,
    output logic       ps_txd,
    input  logic       vib_small,
    input  logic [7:0] vib_large,
    output logic [7:0] pad_id,
    output logic [15:0] btn,
    output logic [7:0] ana_rx,
    output logic [7:0] ana_ry,
    output logic [7:0] ana_lx,
    output logic [7:0] ana_ly,
    output logic       valid,
    output logic       present
);
    localparam int DIV_W    = (HALF_DIV > 2) ? $clog2(HALF_DIV) : 1;
    localparam int POLL_MAX = 2 * POLL_PERIOD;
    localparam int POLL_W   = $clog2(POLL_MAX + 1);
    localparam int HC_W     = (2 * BYTE_GAP > 16) ? $clog2(2 * BYTE_GAP) : 4;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_GAP, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q;
    logic [POLL_W-1:0] poll_q, poll_d;
    logic [HC_W-1:0]   hcnt_q, hcnt_d;
    logic [3:0]        idx_q, idx_d, flen_q, flen_d;
    logic [7:0]        shift_q, shift_d, rx_byte, cmd_byte;
    logic              rxd_meta_q, rxd_sync_q;
    logic              ps_clk_q, ps_clk_d, ps_sel_q, ps_sel_d, ps_txd_q, ps_txd_d;
    logic              vib_s_q, vib_s_d;
    logic [7:0]        vib_l_q, vib_l_d;
    logic [7:0]        pad_id_q, pad_id_d, rx_q, rx_d, ry_q, ry_d, lx_q, lx_d, ly_q, ly_d;
    logic [15:0]       btn_q, btn_d;
    logic              valid_q, valid_d, present_q, present_d;
    logic              half_tick, store_en, frame_ok, is_digital;
    logic [7:0]        frame_q [0:8];

    assign half_tick = (div_q == DIV_W'(HALF_DIV - 1));

    always_comb begin
        case (idx_q)
            4'd0:    cmd_byte = 8'h01;
            4'd1:    cmd_byte = 8'h42;
            4'd3:    cmd_byte = {7'd0, vib_s_q};
            4'd4:    cmd_byte = vib_l_q;
            default: cmd_byte = 8'h00;
        endcase
    end

    assign frame_ok   = (frame_q[2] == 8'h5A) && (frame_q[1] != 8'hFF) && (frame_q[1] != 8'h00);
    assign is_digital = (frame_q[1] == 8'h41);

    always_comb begin
        state_d   = state_q;
        poll_d    = poll_q;
        hcnt_d    = hcnt_q;
        idx_d     = idx_q;
        flen_d    = flen_q;
        shift_d   = shift_q;
        ps_clk_d  = ps_clk_q;
        ps_sel_d  = ps_sel_q;
        ps_txd_d  = ps_txd_q;
        vib_s_d   = vib_s_q;
        vib_l_d   = vib_l_q;
        pad_id_d  = pad_id_q;
        btn_d     = btn_q;
        rx_d      = rx_q;
        ry_d      = ry_q;
        lx_d      = lx_q;
        ly_d      = ly_q;
        valid_d   = 1'b0;
        present_d = present_q;
        store_en  = 1'b0;
        rx_byte   = shift_q;
        rx_byte[hcnt_q[3:1]] = rxd_sync_q;

        // Poll counter runs in every state so the poll period is start-to-start.
        if (half_tick && poll_q != POLL_W'(POLL_MAX))
            poll_d = poll_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (half_tick && poll_q >= POLL_W'(POLL_MAX - 1)) begin
                    state_d  = S_SETUP;
                    poll_d   = '0;
                    hcnt_d   = '0;
                    idx_d    = 4'd0;
                    flen_d   = 4'd9;
                    ps_sel_d = 1'b0;
                    vib_s_d  = vib_small;
                    vib_l_d  = vib_large;
                end
            end
            S_SETUP: begin
                if (half_tick) begin
                    if (hcnt_q == HC_W'(1)) begin
                        state_d = S_SHIFT;
                        hcnt_d  = '0;
                    end else begin
                        hcnt_d = hcnt_q + 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                if (half_tick) begin
                    hcnt_d = hcnt_q + 1'b1;
                    if (!hcnt_q[0]) begin
                        ps_clk_d = 1'b0;
                        ps_txd_d = cmd_byte[hcnt_q[3:1]];
                    end else begin
                        ps_clk_d = 1'b1;
                        shift_d  = rx_byte;
                        if (hcnt_q == HC_W'(15)) begin
                            store_en = 1'b1;
                            state_d  = S_GAP;
                            hcnt_d   = '0;
                            if (idx_q == 4'd1 && rx_byte == 8'h41)
                                flen_d = 4'd5;
                        end
                    end
                end
            end
            S_GAP: begin
                if (half_tick) begin
                    ps_clk_d = 1'b1;
                    ps_txd_d = 1'b1;
                    hcnt_d   = hcnt_q + 1'b1;
                    if (hcnt_q == HC_W'(2 * BYTE_GAP - 1)) begin
                        hcnt_d = '0;
                        if (idx_q == flen_q - 4'd1) begin
                            state_d  = S_DONE;
                            ps_sel_d = 1'b1;
                        end else begin
                            state_d = S_SHIFT;
                            idx_d   = idx_q + 4'd1;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d   = S_IDLE;
                present_d = frame_ok;
                valid_d   = frame_ok;
                if (frame_ok) begin
                    pad_id_d = frame_q[1];
                    btn_d    = {frame_q[4], frame_q[3]};
                    // Digital frames stop after byte 4, so stick bytes are stale.
                    rx_d = is_digital ? 8'h80 : frame_q[5];
                    ry_d = is_digital ? 8'h80 : frame_q[6];
                    lx_d = is_digital ? 8'h80 : frame_q[7];
                    ly_d = is_digital ? 8'h80 : frame_q[8];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            div_q      <= '0;
            poll_q     <= '0;
            hcnt_q     <= '0;
            idx_q      <= 4'd0;
            flen_q     <= 4'd9;
            shift_q    <= 8'hFF;
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            ps_clk_q   <= 1'b1;
            ps_sel_q   <= 1'b1;
            ps_txd_q   <= 1'b1;
            vib_s_q    <= 1'b0;
            vib_l_q    <= 8'h00;
            pad_id_q   <= 8'hFF;
            btn_q      <= 16'hFFFF;
            rx_q       <= 8'h80;
            ry_q       <= 8'h80;
            lx_q       <= 8'h80;
            ly_q       <= 8'h80;
            valid_q    <= 1'b0;
            present_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= half_tick ? '0 : div_q + 1'b1;
            poll_q     <= poll_d;
            hcnt_q     <= hcnt_d;
            idx_q      <= idx_d;
            flen_q     <= flen_d;
            shift_q    <= shift_d;
            rxd_meta_q <= ps_rxd;
            rxd_sync_q <= rxd_meta_q;
            ps_clk_q   <= ps_clk_d;
            ps_sel_q   <= ps_sel_d;
            ps_txd_q   <= ps_txd_d;
            vib_s_q    <= vib_s_d;
            vib_l_q    <= vib_l_d;
            pad_id_q   <= pad_id_d;
            btn_q      <= btn_d;
            rx_q       <= rx_d;
            ry_q       <= ry_d;
            lx_q       <= lx_d;
            ly_q       <= ly_d;
            valid_q    <= valid_d;
            present_q  <= present_d;
        end
    end

    always_ff @(posedge clk) begin
        if (store_en)
            frame_q[idx_q] <= rx_byte;
    end

    assign ps_clk  = ps_clk_q;
    assign ps_sel  = ps_sel_q;
    assign ps_txd  = ps_txd_q;
    assign pad_id  = pad_id_q;
    assign btn     = btn_q;
    assign ana_rx  = rx_q;
    assign ana_ry  = ry_q;
    assign ana_lx  = lx_q;
    assign ana_ly  = ly_q;
    assign valid   = valid_q;
    assign present = present_q;
endmodule

// File: tb/tb_psx_pad_engine.sv
// Directed bench for psx_pad_engine with a behavioural pad that answers on psCLK edges.
module tb_psx_pad_engine;
    localparam int H = 4;
    localparam int G = 2;
    localparam int P = 200;
    localparam int IDLE_CLKS = 2 * P * H;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ps_rxd;
    logic        ps_clk, ps_sel, ps_txd;
    logic        vib_small = 1'b0;
    logic [7:0]  vib_large = 8'h00;
    logic [7:0]  pad_id, ana_rx, ana_ry, ana_lx, ana_ly;
    logic [15:0] btn;
    logic        valid, present;

    psx_pad_engine #(.HALF_DIV(H), .BYTE_GAP(G), .POLL_PERIOD(P)) dut (
        .clk(clk), .rst(rst), .ps_rxd(ps_rxd), .ps_clk(ps_clk), .ps_sel(ps_sel),
        .ps_txd(ps_txd), .vib_small(vib_small), .vib_large(vib_large), .pad_id(pad_id),
        .btn(btn), .ana_rx(ana_rx), .ana_ry(ana_ry), .ana_lx(ana_lx), .ana_ly(ana_ly),
        .valid(valid), .present(present)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pad model: drives DATA after psCLK falls, captures CMD on psCLK rise.
    logic [7:0] resp [0:8];
    logic [7:0] cmd_cap [0:15];
    logic       pad_on = 1'b1;
    logic       pad_bit = 1'b1;
    logic       prev_clk = 1'b1, prev_sel = 1'b1;
    int         m_byte = 0, m_bit = 0, frame_bytes = 0;
    int         cyc = 0, last_fall = 0, clk_per = 0, vcount = 0;

    assign ps_rxd = ps_sel ? 1'b1 : pad_bit;

    always @(posedge clk) cyc++;
    always @(negedge clk) if (valid) vcount++;

    always @(negedge clk) begin
        if (ps_sel) begin
            if (!prev_sel) frame_bytes = m_byte;
            m_byte  = 0;
            m_bit   = 0;
            pad_bit = 1'b1;
        end else begin
            if (prev_clk && !ps_clk) begin
                if (m_byte == 0 && m_bit == 1) clk_per = cyc - last_fall;
                last_fall = cyc;
                pad_bit = (pad_on && m_byte < 9) ? resp[m_byte][m_bit] : 1'b1;
            end
            if (!prev_clk && ps_clk && m_byte < 16) begin
                cmd_cap[m_byte][m_bit] = ps_txd;
                if (m_bit == 7) begin
                    m_bit = 0;
                    m_byte++;
                end else begin
                    m_bit++;
                end
            end
        end
        prev_clk = ps_clk;
        prev_sel = ps_sel;
    end

    task automatic set_analog();
        resp[0] = 8'hFF; resp[1] = 8'h73; resp[2] = 8'h5A; resp[3] = 8'hFE; resp[4] = 8'h7F;
        resp[5] = 8'h10; resp[6] = 8'h20; resp[7] = 8'h30; resp[8] = 8'h40;
    endtask

    task automatic set_digital();
        resp[0] = 8'hFF; resp[1] = 8'h41; resp[2] = 8'h5A; resp[3] = 8'hEF; resp[4] = 8'hFF;
        resp[5] = 8'h55; resp[6] = 8'h66; resp[7] = 8'h77; resp[8] = 8'h88;
    endtask

    // Call right after rst is released on a negedge; counts clks to SEL falling.
    task automatic measure_start(input string tag);
        int n = 0;
        logic clk_low = 1'b0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (!ps_clk) clk_low = 1'b1;
        end while (ps_sel && n < 3 * IDLE_CLKS);
        chk({tag, "_delay"}, n, IDLE_CLKS);
        chk({tag, "_idle_clk_high"}, clk_low, 1'b0);
    endtask

    task automatic wait_sel_fall();
        int n = 0;
        while (ps_sel && n < 4 * IDLE_CLKS) begin
            @(negedge clk);
            n++;
        end
        chk("sel_fall_timeout", ps_sel, 1'b0);
    endtask

    task automatic wait_sel_rise();
        int n = 0;
        while (!ps_sel && n < IDLE_CLKS) begin
            @(negedge clk);
            n++;
        end
        chk("sel_rise_timeout", ps_sel, 1'b1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int v0;
        int n;
        set_analog();
        repeat (5) @(negedge clk);
        chk("rst_sel", ps_sel, 1'b1);
        chk("rst_clk", ps_clk, 1'b1);
        chk("rst_txd", ps_txd, 1'b1);
        chk("rst_btn", btn, 16'hFFFF);
        chk("rst_ana", {ana_rx, ana_ry, ana_lx, ana_ly}, 32'h80808080);
        chk("rst_id", pad_id, 8'hFF);
        chk("rst_present", present, 1'b0);
        chk("rst_valid", valid, 1'b0);

        // Analog pad, first poll
        rst = 1'b0;
        v0 = vcount;
        measure_start("first_poll");
        chk("idle_btn", btn, 16'hFFFF);
        chk("idle_present", present, 1'b0);
        wait_sel_rise();
        chk("an_id", pad_id, 8'h73);
        chk("an_btn", btn, 16'h7FFE);
        chk("an_ana", {ana_rx, ana_ry, ana_lx, ana_ly}, 32'h10203040);
        chk("an_present", present, 1'b1);
        chk("an_valid_cnt", vcount - v0, 1);
        chk("an_bytes", frame_bytes, 9);
        chk("an_cmd", {cmd_cap[0], cmd_cap[1], cmd_cap[2], cmd_cap[3]}, 32'h01420000);
        chk("an_cmd4", cmd_cap[4], 8'h00);
        chk("an_clk_period", clk_per, 2 * H);
        $display("analog poll: id=%0h btn=%0h ana=%0h%0h%0h%0h", pad_id, btn, ana_rx, ana_ry, ana_lx, ana_ly);

        // Pad removed
        pad_on = 1'b0;
        v0 = vcount;
        wait_sel_fall();
        wait_sel_rise();
        chk("rm_present", present, 1'b0);
        chk("rm_btn", btn, 16'h7FFE);
        chk("rm_ana", {ana_rx, ana_ry, ana_lx, ana_ly}, 32'h10203040);
        chk("rm_id", pad_id, 8'h73);
        chk("rm_valid_cnt", vcount - v0, 0);
        $display("removed poll: present=%0d btn=%0h", present, btn);

        // Digital pad recovers
        pad_on = 1'b1;
        set_digital();
        v0 = vcount;
        wait_sel_fall();
        wait_sel_rise();
        chk("dg_bytes", frame_bytes, 5);
        chk("dg_btn", btn, 16'hFFEF);
        chk("dg_ana", {ana_rx, ana_ry, ana_lx, ana_ly}, 32'h80808080);
        chk("dg_id", pad_id, 8'h41);
        chk("dg_present", present, 1'b1);
        chk("dg_valid_cnt", vcount - v0, 1);
        $display("digital poll: id=%0h btn=%0h bytes=%0d", pad_id, btn, frame_bytes);

        // Vibration bytes sampled at transaction start
        set_analog();
        vib_small = 1'b1;
        vib_large = 8'hC0;
        wait_sel_fall();
        repeat (20) @(negedge clk);
        vib_small = 1'b0;
        vib_large = 8'h33;
        wait_sel_rise();
        chk("vib_cmd3", cmd_cap[3], 8'h01);
        chk("vib_cmd4", cmd_cap[4], 8'hC0);
        chk("vib_btn", btn, 16'h7FFE);
        $display("vib poll: cmd3=%0h cmd4=%0h", cmd_cap[3], cmd_cap[4]);

        // Reset during byte 5
        wait_sel_fall();
        n = 0;
        while (m_byte != 5 && n < IDLE_CLKS) begin
            @(negedge clk);
            n++;
        end
        chk("byte5_reached", m_byte, 5);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_sel", ps_sel, 1'b1);
        chk("mid_rst_clk", ps_clk, 1'b1);
        chk("mid_rst_btn", btn, 16'hFFFF);
        chk("mid_rst_ana", {ana_rx, ana_ry, ana_lx, ana_ly}, 32'h80808080);
        chk("mid_rst_id", pad_id, 8'hFF);
        chk("mid_rst_present", present, 1'b0);
        rst = 1'b0;
        measure_start("post_rst_poll");
        $display("reset mid-frame: next poll after %0d clk budget", IDLE_CLKS);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
